// File: rtl/shift_seq_pkg.sv
// Shared constants for the iterative rotate sequencer: state encoding,
// rotate direction codes and default datapath sizes.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;
  localparam int DEF_REPW  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_rot_core.sv
// Combinational bidirectional barrel rotator, one 2:1 mux stage per bit
// of the shift amount.
module rot_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  output logic [WIDTH-1:0] rot
);

  logic [SHW:0][WIDTH-1:0] stg;

  assign stg[0] = data;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int K = 1 << s;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;

    assign rot_l = (stg[s] << K) | (stg[s] >> (WIDTH - K));
    assign rot_r = (stg[s] >> K) | (stg[s] << (WIDTH - K));

    always_comb begin
      stg[s+1] = stg[s];
      if (shamt[s]) begin
        if (dir == DIR_RIGHT) stg[s+1] = rot_r;
        else                  stg[s+1] = rot_l;
      end
    end
  end

  assign rot = stg[SHW];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative rotate sequencer: accepts a command, rotates the operand once
// per clock for the requested repeat count, then presents the result.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a command, in_ready high
//   RUN     | one rotate step per cycle, rem counts down to terminal 1
//   DONE    | result held on out_data until consumed; may accept next cmd
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW,
  parameter int REPW  = DEF_REPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic [REPW-1:0]  in_reps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   shamt_q;
  logic             dir_q;
  logic [REPW-1:0]  rem;
  logic [WIDTH-1:0] rot_data;
  logic             accept;
  logic             last_step;

  rot_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_rot_core (
    .data  (acc),
    .shamt (shamt_q),
    .dir   (dir_q),
    .rot   (rot_data)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (rem == REPW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = (in_reps == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = (in_reps == '0) ? ST_DONE : ST_RUN;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  end

  // Accept takes priority: in DONE the handshake edge reloads the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      rem     <= '0;
    end else if (accept) begin
      acc     <= in_data;
      shamt_q <= in_shamt;
      dir_q   <= in_dir;
      rem     <= in_reps;
    end else if (state_q == ST_RUN) begin
      acc     <= rot_data;
      rem     <= rem - REPW'(1);
    end
  end

  assign out_data = acc;

endmodule
